s_vec_packer: RTL
=================

Name: s_vec_packer

Overview:
- Downstream consumer of the secret-vector sampler.
- Accepts the (L+K)×256 signed coefficients of s1 then s2, one per handshake, and emits the FIPS 204 BitPack(s, η, η) byte stream used in the private-key encoding.
- Each coefficient c is mapped to η−c and packed into b bits, little-endian.
- Feeds the sk byte assembler / SHAKE absorber with a byte-wide valid/ready stream.

Parameters:
- ETA, 2, noise bound η; only 2 and 4 are legal. Elaboration fails otherwise.
- L, 4, number of s1 polynomials.
- K, 4, number of s2 polynomials.
- CW, $clog2(ETA)+3, signed coefficient input width; matches the sampler output width.
- B, (ETA==2)?3:4, packed bits per coefficient; derived, not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  one-cycle pulse; arms a new packing run
- coef_in  in  CW (signed)  coefficient, s1[0][0] first, s2[K-1][255] last
- coef_valid  in  1  coef_in is valid
- coef_ready  out  1  block accepts coef_in this cycle
- byte_out  out  8  packed byte
- byte_valid  out  1  byte_out is valid
- byte_ready  in  1  consumer accepts byte_out
- busy  out  1  high in RUN
- done  out  1  high in DONE
- range_err  out  1  sticky: a coefficient outside [−η, η] was seen this run

Behaviour:
- Reset rst, asynchronous, active-high; clock clk. rst forces state IDLE and clears all outputs, the bit buffer, bit count and counters to 0. Reset mid-run abandons the run with no partial flush.
- FSM states:
  - IDLE: start → RUN; clears range_err, counters and buffer.
  - RUN: after the final byte handshake → DONE.
  - DONE: holds done=1; start → RUN with the same clears as IDLE.
  - start is ignored in RUN.
- Bit buffer: 12 bits, with a 4-bit fill count nb.
- Accept rule: coef_ready = (state==RUN) && (nb<8) && (coef_cnt < (L+K)*256).
  - On a coefficient handshake: v = (ETA − coef_in) truncated to B bits; buf |= v<<nb; nb += B; coef_cnt++.
- Emit rule: byte_valid = (state==RUN) && (nb≥8); byte_out = buf[7:0], driven combinationally from registers.
  - On a byte handshake: buf >>= 8; nb −= 8; byte_cnt++.
- Accept and emit are mutually exclusive by construction (nb<8 vs nb≥8), so there are no simultaneous buffer updates.
- byte_out is stable while byte_valid && !byte_ready.
- Total output: (L+K)*256*B/8 bytes (768 for η=2, 1024 for η=4). Both cases are byte-aligned, so no tail padding is needed and nb==0 at the end.
- Transition to DONE happens on the handshake of the final byte; done asserts the next cycle.
- Range check: if coef_in < −ETA or coef_in > ETA on a handshake, set range_err. The truncated value is still packed, and the run continues.
- coef_valid while coef_ready=0 is a stall, not an error. Inputs after coef_cnt is reached are not accepted.
- Latency: first byte_valid the cycle after the coefficient handshake that makes nb≥8. That is 3 coefficients for η=2 (nb=9) and 2 for η=4.

Decomposition:
- Dilithium_pkg holds:
  - eta, l, k
  - coefficient width constant
  - function eta_bits(eta)
  - constant S_PACK_BYTES = (l+k)*256*eta_bits(eta)/8
- One sub-module: bit_accum (parameter IN_W). Holds the 12-bit buffer, nb, push/pop and byte view. The top holds the FSM, counters and range check.

Test Plan:
- η=2, coefficients 2,1,0,−1,−2,2,2,2 (packed values 0,1,2,3,4,0,0,0) with byte_ready=1 → bytes 0x88, 0x46, 0x00.
- η=2, full run of 2048 zeros → 768 bytes repeating 0x92, 0x24, 0x49; done high the cycle after byte 767; range_err=0.
- η=4, coefficients 4,−4 → byte 0x80; all-zero run → 1024 bytes of 0x44.
- Backpressure: hold byte_ready=0 for 5 cycles while byte_valid=1 → byte_out unchanged and coef_ready=0 throughout; no bytes lost or duplicated versus the golden stream.
- η=2, coefficient 3 at index 10 → range_err rises after that handshake and stays high through DONE; packed value 3'b111; range_err cleared by the next start.
- Assert rst at byte 300 → all outputs 0 the same cycle. A new start then yields the correct full stream from byte 0.

Source files
------------

// File: rtl/s_vec_packer_pkg.sv
// Shared constants and helpers for the secret-vector BitPack(s, eta, eta) packer.
package s_vec_packer_pkg;

  localparam int ETA_DEFAULT = 2;
  localparam int L_DEFAULT   = 4;
  localparam int K_DEFAULT   = 4;
  localparam int N_COEF      = 256;

  localparam int BUF_W = 12;
  localparam int NB_W  = 4;

  function automatic int eta_bits(input int eta);
    return (eta == 2) ? 3 : 4;
  endfunction

  function automatic int coef_width(input int eta);
    return $clog2(eta) + 3;
  endfunction

  localparam int COEF_W       = coef_width(ETA_DEFAULT);
  localparam int S_PACK_BYTES = (L_DEFAULT + K_DEFAULT) * N_COEF * eta_bits(ETA_DEFAULT) / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/s_vec_packer_bit_accum.sv
// 12-bit little-endian bit accumulator: packs IN_W-bit fields in, drains whole bytes out.
module s_vec_packer_bit_accum
  import s_vec_packer_pkg::*;
#(
  parameter int IN_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            push,
  input  logic [IN_W-1:0] push_val,
  input  logic            pop,
  output logic [7:0]      byte_view,
  output logic [NB_W-1:0] nb
);

  logic [BUF_W-1:0] acc;

  // Push only happens with nb<8 and pop only with nb>=8, so the two never collide
  // and a push never overflows the 12-bit buffer (max top bit 7+4-1 = 10).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      nb  <= '0;
    end else if (clr) begin
      acc <= '0;
      nb  <= '0;
    end else if (push) begin
      acc <= acc | (BUF_W'(push_val) << nb);
      nb  <= nb + NB_W'(IN_W);
    end else if (pop) begin
      acc <= acc >> 8;
      nb  <= nb - NB_W'(8);
    end
  end

  assign byte_view = acc[7:0];

endmodule

// File: rtl/s_vec_packer.sv
// Streams s1||s2 coefficients in, emits the BitPack(s, eta, eta) byte stream out.
module s_vec_packer
  import s_vec_packer_pkg::*;
#(
  parameter int ETA = ETA_DEFAULT,
  parameter int L   = L_DEFAULT,
  parameter int K   = K_DEFAULT,
  parameter int CW  = $clog2(ETA) + 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic signed [CW-1:0] coef_in,
  input  logic                 coef_valid,
  output logic                 coef_ready,
  output logic [7:0]           byte_out,
  output logic                 byte_valid,
  input  logic                 byte_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 range_err
);

  localparam int B     = eta_bits(ETA);
  localparam int N_IN  = (L + K) * N_COEF;
  localparam int N_OUT = N_IN * B / 8;
  localparam int CC_W  = $clog2(N_IN + 1);
  localparam int BC_W  = $clog2(N_OUT + 1);

  localparam logic signed [CW:0] ETA_S     = (CW + 1)'(ETA);
  localparam logic signed [CW:0] NEG_ETA_S = -ETA_S;

  if (!(ETA == 2 || ETA == 4)) begin : g_bad_eta
    $error("s_vec_packer: ETA must be 2 or 4");
  end

  // eta - c wraps naturally; an out-of-range c still packs its low B bits.
  function automatic logic [B-1:0] map_coef(input logic signed [CW-1:0] c);
    logic signed [CW:0] d;
    d = ETA_S - $signed({c[CW-1], c});
    return d[B-1:0];
  endfunction

  function automatic logic out_of_range(input logic signed [CW-1:0] c);
    logic signed [CW:0] cx;
    cx = $signed({c[CW-1], c});
    return (cx < NEG_ETA_S) || (cx > ETA_S);
  endfunction

  state_t          state;
  logic [CC_W-1:0] coef_cnt;
  logic [BC_W-1:0] byte_cnt;
  logic [NB_W-1:0] nb;
  logic            coef_hs;
  logic            byte_hs;
  logic            last_byte;
  logic            clr;

  assign coef_ready = (state == ST_RUN) && (nb < NB_W'(8)) && (coef_cnt < CC_W'(N_IN));
  assign byte_valid = (state == ST_RUN) && (nb >= NB_W'(8));
  assign coef_hs    = coef_valid && coef_ready;
  assign byte_hs    = byte_valid && byte_ready;
  assign last_byte  = (byte_cnt == BC_W'(N_OUT - 1));
  assign clr        = start && (state != ST_RUN);

  s_vec_packer_bit_accum #(
    .IN_W (B)
  ) u_accum (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .push      (coef_hs),
    .push_val  (map_coef(coef_in)),
    .pop       (byte_hs),
    .byte_view (byte_out),
    .nb        (nb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      range_err <= 1'b0;
      coef_cnt  <= '0;
      byte_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            range_err <= 1'b0;
            coef_cnt  <= '0;
            byte_cnt  <= '0;
          end
        end
        ST_RUN: begin
          if (coef_hs) begin
            coef_cnt <= coef_cnt + CC_W'(1);
            if (out_of_range(coef_in)) range_err <= 1'b1;
          end
          if (byte_hs) begin
            byte_cnt <= byte_cnt + BC_W'(1);
            if (last_byte) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
